sevenseg_scan_decoder: RTL and testbench

//   Receive end of the multiplexed 7-segment interface: samples the AN/CAT scan driven by a

---
 rtl/sevenseg_scan_decoder_if.sv | 24 ++
 rtl/sevenseg_scan_decoder.sv | 189 ++++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_decoder_if.sv
// Bundle of the multiplexed 7-segment scan lines and the decoded results.
// The master modport drives the scan; the slave modport receives it and reports results.
interface sevenseg_scan_decoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic [NUM_DIGITS-1:0]   an_in;
  logic [6:0]              cat_in;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    seg_err;
  logic                    an_err;
  logic                    scan_stall;

  modport master (
    output an_in, cat_in,
    input  digits, digit_valid, frame_done, seg_err, an_err, scan_stall
  );

  modport slave (
    input  an_in, cat_in,
    output digits, digit_valid, frame_done, seg_err, an_err, scan_stall
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: samples the AN/CAT scan, waits for a
// stable dwell, and rebuilds per-digit hex values plus frame, error and stall indications.
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 1000000
) (
  input  logic                    clk_in,
  input  logic                    rst,
  sevenseg_scan_decoder_if.slave  bus
);
  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   an_s_q, an_p_q;
  logic [6:0]              cat_s_q, cat_p_q;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    seg_err_q, seg_err_d;
  logic                    an_err_q, an_err_d;
  logic                    scan_stall_q, scan_stall_d;

  logic [NUM_DIGITS-1:0]   an_act, prev_act;
  logic                    an_none, an_one, an_multi, prev_multi, s_changed;
  logic                    capture, cap_blank, glyph_ok;
  logic [3:0]              glyph_val;

  // Idle values for the sample pipeline are "no anode, all segments dark", so reset
  // never looks like a multi-hot scan.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      an_s_q  <= '1;
      an_p_q  <= '1;
      cat_s_q <= 7'h7F;
      cat_p_q <= 7'h7F;
    end else begin
      an_s_q  <= bus.an_in;
      cat_s_q <= bus.cat_in;
      an_p_q  <= an_s_q;
      cat_p_q <= cat_s_q;
    end
  end

  always_comb begin
    an_act     = ~an_s_q;
    prev_act   = ~an_p_q;
    an_none    = (an_act == '0);
    an_one     = !an_none && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
    an_multi   = !an_none && !an_one;
    prev_multi = (prev_act != '0) && ((prev_act & (prev_act - NUM_DIGITS'(1))) != '0);
    s_changed  = (an_s_q != an_p_q) || (cat_s_q != cat_p_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (an_one) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!an_one) begin
          state_d = IDLE;
        end else if (s_changed) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!an_one) begin
          state_d = IDLE;
        end else if (s_changed) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (cat_s_q)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h10: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // The capture cycle needs one more unchanged sample after the counter fills.
  always_comb begin
    capture      = (state_q == SETTLE) && !s_changed && (cnt_q == CNT_W'(SETTLE_CYCLES));
    cap_blank    = (cat_s_q == 7'h7F);
    seen_d       = ((&seen_q) ? '0 : seen_q) | (capture ? an_act : '0);
    frame_done_d = &seen_q;
    seg_err_d    = capture && !glyph_ok && !cap_blank;
    an_err_d     = an_multi && !prev_multi;
    if (capture) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == STALL_W'(STALL_CYCLES)) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
    scan_stall_d = (stall_cnt_d == STALL_W'(STALL_CYCLES));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      seen_q       <= '0;
      stall_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      seg_err_q    <= 1'b0;
      an_err_q     <= 1'b0;
      scan_stall_q <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      stall_cnt_q  <= stall_cnt_d;
      frame_done_q <= frame_done_d;
      seg_err_q    <= seg_err_d;
      an_err_q     <= an_err_d;
      scan_stall_q <= scan_stall_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] val_q;
      logic       ok_q;

      // Blank and illegal patterns invalidate the digit but keep its last value.
      always_ff @(posedge clk_in) begin
        if (rst) begin
          val_q <= 4'h0;
          ok_q  <= 1'b0;
        end else if (capture && an_act[gi]) begin
          if (glyph_ok) begin
            val_q <= glyph_val;
          end
          ok_q <= glyph_ok;
        end
      end

      assign bus.digits[4*gi +: 4] = val_q;
      assign bus.digit_valid[gi]   = ok_q;
    end
  endgenerate

  assign bus.frame_done = frame_done_q;
  assign bus.seg_err    = seg_err_q;
  assign bus.an_err     = an_err_q;
  assign bus.scan_stall = scan_stall_q;
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed scan vectors with a scoreboard: the stimulus queues expected output events and
// a monitor compares every observed output event against the queue head.
module tb_sevenseg_scan_decoder;
  localparam int N      = 8;
  localparam int SET    = 4;
  localparam int STALL  = 100;
  localparam int DWELL  = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sevenseg_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

  sevenseg_scan_decoder #(
    .NUM_DIGITS(N), .SETTLE_CYCLES(SET), .STALL_CYCLES(STALL)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] dg;
    logic [7:0]  vl;
    logic        fd;
    logic        se;
    logic        ae;
    logic        st;
  } ev_t;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_digits;
  logic [7:0]  m_valid;
  logic [6:0]  gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic push(input logic fd, input logic se, input logic ae, input logic st);
    ev_t e;
    e = '{dg: m_digits, vl: m_valid, fd: fd, se: se, ae: ae, st: st};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] cat, input int n);
    @(negedge clk);
    bus.an_in  = an;
    bus.cat_in = cat;
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: any pulse or any change of a level output is one event.
  initial begin
    ev_t last, cur, e;
    wait (mon_en);
    last = {bus.digits, bus.digit_valid, bus.frame_done, bus.seg_err, bus.an_err, bus.scan_stall};
    forever begin
      @(negedge clk);
      cur = {bus.digits, bus.digit_valid, bus.frame_done, bus.seg_err, bus.an_err, bus.scan_stall};
      if (cur.fd || cur.se || cur.ae || cur.dg != last.dg || cur.vl != last.vl || cur.st != last.st) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event got=%h expected=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL event got=%h expected=%h", cur, e);
          end else begin
            $display("ok   event dg=%h vl=%h fd=%b se=%b ae=%b st=%b",
                     cur.dg, cur.vl, cur.fd, cur.se, cur.ae, cur.st);
          end
        end
      end
      last = cur;
    end
  end

  initial begin
    rst        = 1'b1;
    bus.an_in  = 8'hFF;
    bus.cat_in = 7'h7F;
    m_digits   = '0;
    m_valid    = '0;

    // Reset and idle scan
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", bus.digits, 32'h0);
    chk("reset_flags", 32'({bus.digit_valid, bus.frame_done, bus.seg_err, bus.an_err, bus.scan_stall}), 32'h0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 7'h7F, 50);
    chk("idle_digits", bus.digits, 32'h0);
    chk("idle_flags", 32'({bus.digit_valid, bus.frame_done, bus.seg_err, bus.an_err, bus.scan_stall}), 32'h0);

    // Full frame "01234567"
    for (int d = 0; d < N; d++) begin
      m_digits[4*d +: 4] = 4'(d);
      m_valid[d]         = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0);
      if (d == N - 1) push(1'b1, 1'b0, 1'b0, 1'b0);
      drive(~(8'h01 << d), gly[d], DWELL);
    end
    chk("frame_digits", bus.digits, 32'h76543210);
    chk("frame_valid", 32'(bus.digit_valid), 32'hFF);

    // Blank then illegal pattern on digit 2
    m_valid[2] = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'hFB, 7'h7F, 20);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'hFB, 7'h55, 20);
    chk("digit2_kept", 32'(bus.digits[11:8]), 32'h2);

    // Two anodes active
    push(1'b0, 1'b0, 1'b1, 1'b0);
    drive(8'hFC, 7'h7F, 10);
    drive(8'hFF, 7'h7F, 5);

    // Glitching cathodes never settle, then a steady "1" on digit 0
    for (int k = 0; k < 5; k++) drive(8'hFE, (k % 2 == 0) ? 7'h40 : 7'h79, 2);
    m_digits[3:0] = 4'h1;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.an_in  = 8'hFE;
    bus.cat_in = 7'h79;
    for (int k = 0; k <= SET + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == SET)     chk("latency_before", 32'(bus.digits[3:0]), 32'h0);
      if (k == SET + 1) chk("latency_at", 32'(bus.digits[3:0]), 32'h1);
    end

    // Stop the scan until stall, then resume
    push(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.an_in  = 8'hFF;
    bus.cat_in = 7'h7F;
    for (int k = 1; k <= STALL; k++) begin
      @(posedge clk);
      #1;
      if (k == STALL - 1) chk("stall_before", 32'(bus.scan_stall), 32'h0);
      if (k == STALL)     chk("stall_at", 32'(bus.scan_stall), 32'h1);
    end
    push(1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'hFE, 7'h79, 20);
    chk("stall_cleared", 32'(bus.scan_stall), 32'h0);

    // Reset in the middle of a settle window
    m_digits = '0;
    m_valid  = '0;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'hFD, gly[9], 2);
    @(negedge clk);
    rst        = 1'b1;
    bus.an_in  = 8'hFF;
    bus.cat_in = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 7'h7F, 20);
    chk("mid_settle_digits", bus.digits, 32'h0);
    chk("mid_settle_flags", 32'({bus.digit_valid, bus.frame_done, bus.seg_err, bus.an_err, bus.scan_stall}), 32'h0);

    repeat (5) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
